// File: rtl/mem_pkg.sv
// Shared memory-access encodings and defaults for the MEM stage.
package mem_pkg;
  localparam int DEF_NBITS = 32;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b11;

  // 2'b10 is not a legal encoding; it behaves as a word access
  function automatic logic size_is_word(input logic [1:0] sz);
    return sz[1];
  endfunction
endpackage

// File: rtl/load_align.sv
// Lane select, sign/zero extension and misalign detect for loads, plus
// byte-enable and lane-replicated write data for stores, from one size code.
import mem_pkg::*;

module load_align #(
  parameter int NBITS = DEF_NBITS
) (
  input  logic [1:0]         addr,
  input  logic [1:0]         size,
  input  logic               sign,
  input  logic [NBITS-1:0]   rdata,
  input  logic [NBITS-1:0]   st_data,
  output logic [NBITS-1:0]   ld_data,
  output logic               misalign,
  output logic [NBITS/8-1:0] byte_en,
  output logic [NBITS-1:0]   wdata
);
  localparam int NLANES = NBITS / 8;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // little-endian lane pick from the addressed word
  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // extension, misalign and store lane generation per access size
  always_comb begin
    ld_data  = rdata;
    misalign = 1'b0;
    byte_en  = '1;
    wdata    = st_data;
    if (size == MEM_BYTE) begin
      ld_data = {{(NBITS-8){sign & byte_sel[7]}}, byte_sel};
      byte_en = NLANES'(1) << addr;
      wdata   = {NLANES{st_data[7:0]}};
    end else if (size == MEM_HALF) begin
      ld_data  = {{(NBITS-16){sign & half_sel[15]}}, half_sel};
      misalign = addr[0];
      byte_en  = addr[1] ? NLANES'(4'b1100) : NLANES'(4'b0011);
      wdata    = {(NLANES/2){st_data[15:0]}};
    end else if (size_is_word(size)) begin
      misalign = (addr != 2'b00);
    end
  end
endmodule

// File: rtl/stage_memory.sv
// MIPS MEM stage: word-organised data memory with byte/half/word access and
// the MEM/WB pipeline register. Define STAGE_MEMORY_DEBUG_EN for a second
// asynchronous read port (i_dbg_addr / o_dbg_data) for the debug unit.
import mem_pkg::*;

module stage_memory #(
  parameter int NBITS     = DEF_NBITS,
  parameter int ADDR_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_flush,
  input  logic [NBITS-1:0]     i_ALU_rslt,
  input  logic [NBITS-1:0]     i_st_data,
  input  logic                 i_flg_mem_wr,
  input  logic                 i_flg_mem_rd,
  input  logic [1:0]           i_mem_size,
  input  logic                 i_flg_mem_sign,
  input  logic [1:0]           i_flg_ALU_dst,
  input  logic [4:0]           i_rd,
  input  logic [4:0]           i_rt,
  input  logic                 i_flg_wb_src,
  input  logic                 i_flg_reg_wr,
  output logic [NBITS-1:0]     o_ALU_rslt,
  output logic [NBITS-1:0]     o_data,
  output logic [1:0]           o_flg_ALU_dst,
  output logic [4:0]           o_rd,
  output logic [4:0]           o_rt,
  output logic                 o_flg_wb_src,
  output logic                 o_flg_reg_wr,
  output logic                 o_misalign
`ifdef STAGE_MEMORY_DEBUG_EN
  ,
  input  logic [ADDR_BITS-1:0] i_dbg_addr,
  output logic [NBITS-1:0]     o_dbg_data
`endif
);
  localparam int DEPTH  = 1 << ADDR_BITS;
  localparam int NLANES = NBITS / 8;

  logic [NBITS-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] widx;
  logic [NBITS-1:0]     rdata, ld_data, wdata;
  logic [NLANES-1:0]    byte_en;
  logic                 misalign, mis_act, st_go;
  logic                 unused_addr_hi;

  // upper address bits wrap modulo the memory depth
  assign widx           = i_ALU_rslt[ADDR_BITS+1:2];
  assign unused_addr_hi = ^i_ALU_rslt[NBITS-1:ADDR_BITS+2];
  assign rdata          = mem[widx];

  load_align #(.NBITS(NBITS)) u_align (
    .addr     (i_ALU_rslt[1:0]),
    .size     (i_mem_size),
    .sign     (i_flg_mem_sign),
    .rdata    (rdata),
    .st_data  (i_st_data),
    .ld_data  (ld_data),
    .misalign (misalign),
    .byte_en  (byte_en),
    .wdata    (wdata)
  );

  // alignment only matters when memory is actually touched
  assign mis_act = misalign & (i_flg_mem_wr | i_flg_mem_rd);
  assign st_go   = i_en & i_flg_mem_wr & ~i_flush & ~mis_act;

  // array write: reset clears every word, stores update enabled lanes only
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (st_go) begin
      for (int l = 0; l < NLANES; l++)
        if (byte_en[l]) mem[widx][l*8 +: 8] <= wdata[l*8 +: 8];
    end
  end

  // MEM/WB register: hold on !i_en, bubble on flush
  always_ff @(posedge i_clk) begin
    if (i_rst || (i_en && i_flush)) begin
      o_ALU_rslt    <= '0;
      o_data        <= '0;
      o_flg_ALU_dst <= '0;
      o_rd          <= '0;
      o_rt          <= '0;
      o_flg_wb_src  <= 1'b0;
      o_flg_reg_wr  <= 1'b0;
      o_misalign    <= 1'b0;
    end else if (i_en) begin
      o_ALU_rslt    <= i_ALU_rslt;
      o_data        <= (i_flg_mem_rd && !mis_act) ? ld_data : '0;
      o_flg_ALU_dst <= i_flg_ALU_dst;
      o_rd          <= i_rd;
      o_rt          <= i_rt;
      o_flg_wb_src  <= i_flg_wb_src;
      o_flg_reg_wr  <= i_flg_reg_wr & ~mis_act;
      o_misalign    <= mis_act;
    end
  end

`ifdef STAGE_MEMORY_DEBUG_EN
  // debug peek: asynchronous, sees pre-store contents until the write edge
  assign o_dbg_data = mem[i_dbg_addr];
`endif
endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory: byte-addressed reference memory plus
// expected MEM/WB fields, compared every cycle, with literal spot checks.
module tb_stage_memory;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1, i_en = 1'b0, i_flush = 1'b0;
  logic [31:0] i_ALU_rslt = '0, i_st_data = '0;
  logic        i_flg_mem_wr = 1'b0, i_flg_mem_rd = 1'b0;
  logic [1:0]  i_mem_size = 2'b11;
  logic        i_flg_mem_sign = 1'b0;
  logic [1:0]  i_flg_ALU_dst = '0;
  logic [4:0]  i_rd = '0, i_rt = '0;
  logic        i_flg_wb_src = 1'b0, i_flg_reg_wr = 1'b0;
  logic [31:0] o_ALU_rslt, o_data;
  logic [1:0]  o_flg_ALU_dst;
  logic [4:0]  o_rd, o_rt;
  logic        o_flg_wb_src, o_flg_reg_wr, o_misalign;
`ifdef STAGE_MEMORY_DEBUG_EN
  logic [7:0]  i_dbg_addr = '0;
  logic [31:0] o_dbg_data;
`endif

  stage_memory dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_flush(i_flush),
    .i_ALU_rslt(i_ALU_rslt), .i_st_data(i_st_data),
    .i_flg_mem_wr(i_flg_mem_wr), .i_flg_mem_rd(i_flg_mem_rd),
    .i_mem_size(i_mem_size), .i_flg_mem_sign(i_flg_mem_sign),
    .i_flg_ALU_dst(i_flg_ALU_dst), .i_rd(i_rd), .i_rt(i_rt),
    .i_flg_wb_src(i_flg_wb_src), .i_flg_reg_wr(i_flg_reg_wr),
    .o_ALU_rslt(o_ALU_rslt), .o_data(o_data), .o_flg_ALU_dst(o_flg_ALU_dst),
    .o_rd(o_rd), .o_rt(o_rt), .o_flg_wb_src(o_flg_wb_src),
    .o_flg_reg_wr(o_flg_reg_wr), .o_misalign(o_misalign)
`ifdef STAGE_MEMORY_DEBUG_EN
    , .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0, n_err = 0;
  logic chk_en = 1'b0;

  // reference state: byte memory and expected MEM/WB fields
  logic [7:0]  mb [1024];
  logic [31:0] e_alu = '0, e_data = '0;
  logic [1:0]  e_dst = '0;
  logic [4:0]  e_rd = '0, e_rt = '0;
  logic        e_wb = 1'b0, e_rw = 1'b0, e_mis = 1'b0;
  // staged values computed from the inputs before the edge
  logic [31:0] n_alu, n_data;
  logic        n_mis, n_store;
  int          n_bytes;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
    int b = (a / 4) * 4;
    return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
  endfunction

  // apply inputs and work out what the next edge must produce
  task automatic drive(input logic en, input logic fl, input logic wr, input logic rd,
                       input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                       input logic [31:0] d, input logic rw);
    int a;
    logic [15:0] h;
    i_en = en; i_flush = fl; i_flg_mem_wr = wr; i_flg_mem_rd = rd;
    i_mem_size = sz; i_flg_mem_sign = sg; i_ALU_rslt = addr; i_st_data = d;
    i_flg_reg_wr = rw;
    i_rd = 5'($urandom); i_rt = 5'($urandom);
    i_flg_ALU_dst = 2'($urandom); i_flg_wb_src = 1'($urandom);
    a = int'(addr[9:0]);
    n_bytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    n_mis = (wr | rd) && (a % n_bytes != 0);
    n_data = 32'h0;
    if (rd && !n_mis) begin
      if (n_bytes == 1)      n_data = (sg && mb[a][7]) ? (32'hFFFFFF00 | 32'(mb[a])) : 32'(mb[a]);
      else if (n_bytes == 2) begin
        h = {mb[a+1], mb[a]};
        n_data = (sg && h[15]) ? (32'hFFFF0000 | 32'(h)) : 32'(h);
      end else               n_data = word_at(a);
    end
    n_store = en && wr && !fl && !n_mis;
  endtask

  // clock edge: advance reference state exactly as the edge should
  task automatic tick();
    int a;
    @(posedge i_clk);
    a = int'(i_ALU_rslt[9:0]);
    if (i_rst) begin
      for (int i = 0; i < 1024; i++) mb[i] = 8'h0;
      {e_alu, e_data, e_dst, e_rd, e_rt, e_wb, e_rw, e_mis} = '0;
    end else if (i_en) begin
      if (i_flush) {e_alu, e_data, e_dst, e_rd, e_rt, e_wb, e_rw, e_mis} = '0;
      else begin
        e_alu = i_ALU_rslt; e_data = n_data; e_dst = i_flg_ALU_dst;
        e_rd = i_rd; e_rt = i_rt; e_wb = i_flg_wb_src;
        e_rw = i_flg_reg_wr & ~n_mis; e_mis = n_mis;
        if (n_store)
          for (int k = 0; k < n_bytes; k++) mb[a+k] = i_st_data[k*8 +: 8];
      end
    end
    #1;
  endtask

  // every-cycle comparison of all registered outputs
  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("alu",    o_ALU_rslt, e_alu);
      chk("data",   o_data, e_data);
      chk("dst",    32'(o_flg_ALU_dst), 32'(e_dst));
      chk("rd",     32'(o_rd), 32'(e_rd));
      chk("rt",     32'(o_rt), 32'(e_rt));
      chk("wb_src", 32'(o_flg_wb_src), 32'(e_wb));
      chk("reg_wr", 32'(o_flg_reg_wr), 32'(e_rw));
      chk("mis",    32'(o_misalign), 32'(e_mis));
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mb[i] = 8'hXX;
    // reset with a store in flight: store must be discarded
    i_rst = 1'b1;
    drive(1, 0, 1, 0, 2'b11, 0, 32'h4, 32'hFFFF_FFFF, 1); tick();
    drive(1, 1, 1, 1, 2'b11, 0, 32'h8, 32'hFFFF_FFFF, 1); tick();
    chk_en = 1'b1;
    chk("rst_all", {o_ALU_rslt | o_data, 27'(0), o_misalign, o_flg_reg_wr, o_flg_wb_src, |o_rd, |o_rt}, 32'h0);
    i_rst = 1'b0;
    drive(1, 0, 0, 1, 2'b11, 0, 32'h4, 0, 1); tick();
    chk("rst_store_discard", o_data, 32'h0);
    drive(1, 0, 0, 1, 2'b11, 0, 32'h0, 0, 1); tick();
    chk("ld_w_0", o_data, 32'h0);

    drive(1, 0, 1, 0, 2'b11, 0, 32'h04, 32'hDEADBEEF, 0); tick();
    drive(1, 0, 0, 1, 2'b00, 1, 32'h04, 0, 1); tick();
    chk("ld_b_s_04", o_data, 32'hFFFFFFEF);
    drive(1, 0, 0, 1, 2'b00, 0, 32'h07, 0, 1); tick();
    chk("ld_b_u_07", o_data, 32'h000000DE);
    drive(1, 0, 0, 1, 2'b01, 1, 32'h06, 0, 1); tick();
    chk("ld_h_s_06", o_data, 32'hFFFFDEAD);
    drive(1, 0, 0, 1, 2'b01, 0, 32'h06, 0, 1); tick();
    chk("ld_h_u_06", o_data, 32'h0000DEAD);

    drive(1, 0, 1, 0, 2'b11, 0, 32'h08, 32'h11223344, 0); tick();
    drive(1, 0, 1, 0, 2'b00, 0, 32'h09, 32'h0000005A, 0); tick();
    drive(1, 0, 0, 1, 2'b11, 0, 32'h08, 0, 1); tick();
    chk("ld_w_08", o_data, 32'h11225A44);

    // misaligned word store
    drive(1, 0, 1, 0, 2'b11, 0, 32'h0A, 32'hFFFFFFFF, 1); tick();
    chk("mis_flag", 32'(o_misalign), 32'h1);
    chk("mis_regwr", 32'(o_flg_reg_wr), 32'h0);
    drive(1, 0, 0, 1, 2'b11, 0, 32'h08, 0, 1); tick();
    chk("mis_nostore", o_data, 32'h11225A44);
    drive(1, 0, 0, 1, 2'b01, 1, 32'h05, 0, 1); tick();
    chk("mis_ld_h", o_data, 32'h0);

    // frozen stage, then flush bubble
    drive(0, 1, 1, 0, 2'b11, 0, 32'h10, 32'hCAFEBABE, 1); tick();
    drive(1, 1, 1, 0, 2'b11, 0, 32'h10, 32'hCAFEBABE, 1); tick();
    chk("flush_alu", o_ALU_rslt, 32'h0);
    drive(1, 0, 0, 1, 2'b11, 0, 32'h10, 0, 1); tick();
    chk("ld_w_10", o_data, 32'h0);

    // simultaneous load/store returns the pre-store word
    drive(1, 0, 1, 0, 2'b11, 0, 32'h14, 32'hAAAABBBB, 0); tick();
    drive(1, 0, 1, 1, 2'b11, 0, 32'h14, 32'h01020304, 1); tick();
    chk("rdwr_old", o_data, 32'hAAAABBBB);
    // address wrap: 0x414 aliases word 0x14; size 10 behaves as word
    drive(1, 0, 0, 1, 2'b10, 0, 32'h0000_0414, 0, 1); tick();
    chk("wrap_ld", o_data, 32'h01020304);
    drive(1, 0, 1, 0, 2'b01, 0, 32'h1A, 32'h1234BEEF, 0); tick();
    drive(1, 0, 0, 1, 2'b11, 0, 32'h18, 0, 1); tick();
    chk("ld_w_18", o_data, 32'hBEEF0000);
    drive(1, 0, 0, 0, 2'b11, 0, 32'h1C, 0, 1); tick();
    chk("noload_data", o_data, 32'h0);

`ifdef STAGE_MEMORY_DEBUG_EN
    i_dbg_addr = 8'd8;
    drive(1, 0, 1, 0, 2'b11, 0, 32'h20, 32'h12345678, 0); #1;
    chk("dbg_before", o_dbg_data, 32'h0);
    chk("dbg_model_pre", o_dbg_data, word_at(32));
    tick();
    chk("dbg_after", o_dbg_data, 32'h12345678);
    chk("dbg_model_post", o_dbg_data, word_at(32));
`endif

    // mid-run reset clears memory again
    i_rst = 1'b1;
    drive(1, 0, 1, 0, 2'b11, 0, 32'h08, 32'h77777777, 1); tick();
    i_rst = 1'b0;
    drive(1, 0, 0, 1, 2'b11, 0, 32'h08, 0, 1); tick();
    chk("rst2_ld_08", o_data, 32'h0);
    drive(1, 0, 0, 0, 2'b11, 0, 0, 0, 0); tick();
    chk_en = 1'b0;
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/stage_memory.md
# stage_memory

Memory stage of the 5-stage MIPS pipeline: byte/half/word loads and stores against a word-organised data memory, plus the MEM/WB pipeline register. Its registered outputs drive the writeback stage directly: ALU result, load data, destination-select flag, rd/rt, write-back source flag and register-write enable. Supports step-enable for the debug unit, bubble insertion and an optional debug read port.

## Interface
- NBITS, 32, datapath width
- ADDR_BITS, 8, word-address width; memory depth = 2^ADDR_BITS words
- i_clk  input  1  clock, rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_en  input  1  pipeline step enable; 0 freezes the stage
- i_flush  input  1  load a bubble into MEM/WB
- i_ALU_rslt  input  NBITS  byte address / ALU result
- i_st_data  input  NBITS  store data (rt value)
- i_flg_mem_wr  input  1  store
- i_flg_mem_rd  input  1  load
- i_mem_size  input  2  00 byte, 01 half, 11 word (10 treated as word)
- i_flg_mem_sign  input  1  1 = sign-extend load, 0 = zero-extend
- i_flg_ALU_dst  input  2  destination select, passed through
- i_rd, i_rt  input  5 each  register ids, passed through
- i_flg_wb_src  input  1  write-back source select, passed through
- i_flg_reg_wr  input  1  register-write enable, passed through
- o_ALU_rslt  output  NBITS  registered ALU result
- o_data  output  NBITS  registered, extended load data
- o_flg_ALU_dst, o_rd, o_rt, o_flg_wb_src, o_flg_reg_wr  output  as inputs  registered pass-through
- o_misalign  output  1  registered misaligned-access flag
- i_dbg_addr  input  ADDR_BITS  debug word address (macro only)
- o_dbg_data  output  NBITS  debug read data (macro only)

## Operation
- Word index = i_ALU_rslt[ADDR_BITS+1:2]; upper address bits ignored (wrap modulo depth). Little-endian lanes.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0, on a load or store.
- Store (i_en & i_flg_mem_wr & !i_flush & !misaligned): byte writes i_st_data[7:0] to lane addr[1:0]; half writes [15:0] to lanes {addr[1],0}+1..0; word writes all lanes; other lanes unchanged.
- Load: word read combinationally, lane selected, extended per i_flg_mem_sign, captured in o_data. When not a load, o_data captures 0.
- Misaligned access: store suppressed, o_data = 0, o_misalign = 1, o_flg_reg_wr forced 0; other fields registered normally.
- Both i_flg_mem_wr and i_flg_mem_rd set: store performed, load returns pre-store word.
- Flush (i_en & i_flush): no store; all MEM/WB outputs register 0 (bubble).
- i_en = 0: memory and all outputs hold; i_flush ignored.

## Timing
- Reset: every output 0, all memory words cleared to 0 on the reset edge; reset overrides i_en and i_flush; reset mid-store discards the store.
- Latency 1 cycle: inputs at edge N appear on outputs after edge N.
- Store at edge N is visible to a load at edge N+1 (back-to-back store/load same address returns new data).
- o_dbg_data is combinational from i_dbg_addr; shows pre-store contents until the write edge.

## Configuration
- STAGE_MEMORY_DEBUG_EN defined: i_dbg_addr/o_dbg_data present, second asynchronous read port on the array.
- Undefined: both ports absent; no extra read logic.

## Structure
- Shared package mem_pkg: size encodings (MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b11), default NBITS.
- Sub-module load_align: combinational lane select + sign/zero extension + misalign detect; reused for store byte-enable generation from the same encodings.
- Top holds the memory array and MEM/WB register.

## Test plan
- Reset then word load addr 0x00 -> o_data 0x00000000, all outputs 0.
- Store word 0xDEADBEEF @0x04, next cycle load byte signed @0x04 -> 0xFFFFFFEF; byte unsigned @0x07 -> 0x000000DE; half signed @0x06 -> 0xFFFFDEAD.
- Store byte 0x5A @0x09 over word 0x11223344 @0x08 -> word load @0x08 returns 0x11225A44.
- Word store @0x0A -> memory unchanged, o_misalign 1, o_flg_reg_wr 0.
- i_en 0 with store 0xCAFEBABE @0x10 then i_en 1 with flush -> word @0x10 still 0, outputs all 0.
- Debug build: store 0x12345678 @0x20, i_dbg_addr 8 -> o_dbg_data 0x12345678 after the write edge, 0 before.
